// File: rtl/gpu_pkg.sv
// Shared definitions for the GPU line-drawing path.
//   - Default coordinate/colour widths and visible screen size.
//   - err_bits(): width of the signed Bresenham error term for given
//     coordinate widths. The extra bits leave headroom for 2*err.
//   - line_state_t: line rasteriser FSM states.
package gpu_pkg;

    localparam int DEF_WIDTH_BITS   = 10;
    localparam int DEF_HEIGHT_BITS  = 9;
    localparam int DEF_CHANNEL_BITS = 8;
    localparam int DEF_SCREEN_W     = 640;
    localparam int DEF_SCREEN_H     = 480;

    function automatic int err_bits(input int w, input int h);
        return ((w > h) ? w : h) + 3;
    endfunction

    localparam int ERR_BITS = err_bits(DEF_WIDTH_BITS, DEF_HEIGHT_BITS);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        DRAW,
        DONE,
        WAIT_LOW
    } line_state_t;

endpackage

// File: rtl/gpu_line_drawer_if.sv
// Pixel write port from the line drawer toward the frame-buffer write port.
//   master (drawer): drives pixel_valid_o and pixel_x/y/r/g/b_o, and samples pixel_ready_i.
//   slave (frame buffer): samples the pixel and drives pixel_ready_i.
// A pixel transfers on any cycle where valid and ready are both high.
interface gpu_line_drawer_if
    import gpu_pkg::*;
#(
    parameter int WIDTH_BITS   = DEF_WIDTH_BITS,
    parameter int HEIGHT_BITS  = DEF_HEIGHT_BITS,
    parameter int CHANNEL_BITS = DEF_CHANNEL_BITS
);
    logic                    pixel_valid_o;
    logic                    pixel_ready_i;
    logic [WIDTH_BITS-1:0]   pixel_x_o;
    logic [HEIGHT_BITS-1:0]  pixel_y_o;
    logic [CHANNEL_BITS-1:0] pixel_r_o;
    logic [CHANNEL_BITS-1:0] pixel_g_o;
    logic [CHANNEL_BITS-1:0] pixel_b_o;

    modport master (
        output pixel_valid_o, pixel_x_o, pixel_y_o, pixel_r_o, pixel_g_o, pixel_b_o,
        input  pixel_ready_i
    );

    modport slave (
        input  pixel_valid_o, pixel_x_o, pixel_y_o, pixel_r_o, pixel_g_o, pixel_b_o,
        output pixel_ready_i
    );
endinterface

// File: rtl/gpu_bresenham_step.sv
// One combinational step of integer Bresenham.
//   cur_x_i/cur_y_i : current point
//   end_x_i/end_y_i : line endpoint
//   err_i           : signed error term
//   dx_i            : +|x2-x1|
//   dy_i            : -|y2-y1|
//   sx_neg_i/sy_neg_i : step direction (1 = decrement)
//   next_x_o/next_y_o/next_err_o : state after one step
//   at_end_o        : current point is the endpoint
module gpu_bresenham_step
    import gpu_pkg::*;
#(
    parameter int WIDTH_BITS  = DEF_WIDTH_BITS,
    parameter int HEIGHT_BITS = DEF_HEIGHT_BITS,
    parameter int ERR_W       = ERR_BITS
)(
    input  logic [WIDTH_BITS-1:0]   cur_x_i,
    input  logic [HEIGHT_BITS-1:0]  cur_y_i,
    input  logic [WIDTH_BITS-1:0]   end_x_i,
    input  logic [HEIGHT_BITS-1:0]  end_y_i,
    input  logic signed [ERR_W-1:0] err_i,
    input  logic signed [ERR_W-1:0] dx_i,
    input  logic signed [ERR_W-1:0] dy_i,
    input  logic                    sx_neg_i,
    input  logic                    sy_neg_i,
    output logic [WIDTH_BITS-1:0]   next_x_o,
    output logic [HEIGHT_BITS-1:0]  next_y_o,
    output logic signed [ERR_W-1:0] next_err_o,
    output logic                    at_end_o
);
    logic signed [ERR_W-1:0] e2;
    logic                    step_x;
    logic                    step_y;

    // Both tests use the error value from before this step, so a diagonal
    // move applies both corrections together.
    always_comb begin
        e2         = err_i <<< 1;
        step_x     = (e2 >= dy_i);
        step_y     = (e2 <= dx_i);
        next_err_o = err_i
                   + (step_x ? dy_i : {ERR_W{1'b0}})
                   + (step_y ? dx_i : {ERR_W{1'b0}});
        next_x_o   = cur_x_i;
        next_y_o   = cur_y_i;
        if (step_x) next_x_o = sx_neg_i ? cur_x_i - 1'b1 : cur_x_i + 1'b1;
        if (step_y) next_y_o = sy_neg_i ? cur_y_i - 1'b1 : cur_y_i + 1'b1;
    end

    assign at_end_o = (cur_x_i == end_x_i) && (cur_y_i == end_y_i);

endmodule

// File: rtl/gpu_line_drawer.sv
// Bresenham line rasteriser that sits after the GPU command decoder.
// On the draw_i level, the module latches the endpoints and colour. It then
// emits every on-screen point of the line, endpoint-inclusive, one pixel per
// accepted handshake on the pix port. It then pulses finished_o and waits
// until draw_i goes low before it accepts a new line.
//   clk, n_rst          : clock, async active-low reset
//   draw_i              : level request from the decoder
//   x1_i/y1_i/x2_i/y2_i : endpoints
//   r_i/g_i/b_i         : line colour
//   pix (master)        : pixel valid/ready write port
//   busy_o              : not IDLE
//   finished_o          : one-cycle completion pulse
module gpu_line_drawer
    import gpu_pkg::*;
#(
    parameter int WIDTH_BITS   = DEF_WIDTH_BITS,
    parameter int HEIGHT_BITS  = DEF_HEIGHT_BITS,
    parameter int CHANNEL_BITS = DEF_CHANNEL_BITS,
    parameter int SCREEN_W     = DEF_SCREEN_W,
    parameter int SCREEN_H     = DEF_SCREEN_H
)(
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic                    draw_i,
    input  logic [WIDTH_BITS-1:0]   x1_i,
    input  logic [HEIGHT_BITS-1:0]  y1_i,
    input  logic [WIDTH_BITS-1:0]   x2_i,
    input  logic [HEIGHT_BITS-1:0]  y2_i,
    input  logic [CHANNEL_BITS-1:0] r_i,
    input  logic [CHANNEL_BITS-1:0] g_i,
    input  logic [CHANNEL_BITS-1:0] b_i,
    gpu_line_drawer_if.master       pix,
    output logic                    busy_o,
    output logic                    finished_o
);
    localparam int ERR_W = err_bits(WIDTH_BITS, HEIGHT_BITS);
    // Screen limits are one bit wider than the coordinates, so the limit itself fits.
    localparam logic [WIDTH_BITS:0]  SCR_W = SCREEN_W[WIDTH_BITS:0];
    localparam logic [HEIGHT_BITS:0] SCR_H = SCREEN_H[HEIGHT_BITS:0];

    line_state_t state_q, state_d;

    logic [WIDTH_BITS-1:0]   x1_q, x2_q;
    logic [HEIGHT_BITS-1:0]  y1_q, y2_q;
    logic signed [ERR_W-1:0] dx_q, dy_q, err_q;
    logic                    sx_neg_q, sy_neg_q;

    // The pixel output registers also hold the current walk position. The
    // point on the port is always the point being evaluated.
    logic                    pv_q;
    logic [WIDTH_BITS-1:0]   px_q;
    logic [HEIGHT_BITS-1:0]  py_q;
    logic [CHANNEL_BITS-1:0] pr_q, pg_q, pb_q;

    logic [WIDTH_BITS-1:0]   dx_mag, nxt_x;
    logic [HEIGHT_BITS-1:0]  dy_mag, nxt_y;
    logic signed [ERR_W-1:0] dx_c, dy_c, nxt_err;
    logic                    at_end, advance, first_on, next_on;

    assign dx_mag   = (x1_q < x2_q) ? x2_q - x1_q : x1_q - x2_q;
    assign dy_mag   = (y1_q < y2_q) ? y2_q - y1_q : y1_q - y2_q;
    assign dx_c     = $signed({{(ERR_W-WIDTH_BITS){1'b0}}, dx_mag});
    assign dy_c     = -$signed({{(ERR_W-HEIGHT_BITS){1'b0}}, dy_mag});
    assign first_on = ({1'b0, x1_q} < SCR_W) && ({1'b0, y1_q} < SCR_H);
    assign next_on  = ({1'b0, nxt_x} < SCR_W) && ({1'b0, nxt_y} < SCR_H);

    // A step is taken when the presented pixel is accepted. A clipped point,
    // which has no valid, also takes a step.
    assign advance  = (state_q == DRAW) && (!pv_q || pix.pixel_ready_i);

    gpu_bresenham_step #(
        .WIDTH_BITS  (WIDTH_BITS),
        .HEIGHT_BITS (HEIGHT_BITS),
        .ERR_W       (ERR_W)
    ) u_step (
        .cur_x_i    (px_q),
        .cur_y_i    (py_q),
        .end_x_i    (x2_q),
        .end_y_i    (y2_q),
        .err_i      (err_q),
        .dx_i       (dx_q),
        .dy_i       (dy_q),
        .sx_neg_i   (sx_neg_q),
        .sy_neg_i   (sy_neg_q),
        .next_x_o   (nxt_x),
        .next_y_o   (nxt_y),
        .next_err_o (nxt_err),
        .at_end_o   (at_end)
    );

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (draw_i) state_d = SETUP;
            SETUP:    state_d = DRAW;
            DRAW:     if (advance && at_end) state_d = DONE;
            DONE:     state_d = WAIT_LOW;
            WAIT_LOW: if (!draw_i) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            x1_q     <= '0;
            y1_q     <= '0;
            x2_q     <= '0;
            y2_q     <= '0;
            dx_q     <= '0;
            dy_q     <= '0;
            err_q    <= '0;
            sx_neg_q <= 1'b0;
            sy_neg_q <= 1'b0;
            pv_q     <= 1'b0;
            px_q     <= '0;
            py_q     <= '0;
            pr_q     <= '0;
            pg_q     <= '0;
            pb_q     <= '0;
        end else begin
            case (state_q)
                IDLE: if (draw_i) begin
                    x1_q <= x1_i;
                    y1_q <= y1_i;
                    x2_q <= x2_i;
                    y2_q <= y2_i;
                    pr_q <= r_i;
                    pg_q <= g_i;
                    pb_q <= b_i;
                end
                SETUP: begin
                    dx_q     <= dx_c;
                    dy_q     <= dy_c;
                    err_q    <= dx_c + dy_c;
                    sx_neg_q <= !(x1_q < x2_q);
                    sy_neg_q <= !(y1_q < y2_q);
                    px_q     <= x1_q;
                    py_q     <= y1_q;
                    pv_q     <= first_on;
                end
                DRAW: if (advance) begin
                    if (at_end) begin
                        pv_q <= 1'b0;
                    end else begin
                        px_q  <= nxt_x;
                        py_q  <= nxt_y;
                        err_q <= nxt_err;
                        pv_q  <= next_on;
                    end
                end
                default: pv_q <= 1'b0;
            endcase
        end
    end

    assign pix.pixel_valid_o = pv_q;
    assign pix.pixel_x_o     = px_q;
    assign pix.pixel_y_o     = py_q;
    assign pix.pixel_r_o     = pr_q;
    assign pix.pixel_g_o     = pg_q;
    assign pix.pixel_b_o     = pb_q;
    assign busy_o            = (state_q != IDLE);
    assign finished_o        = (state_q == DONE);

endmodule

// File: tb/tb_gpu_line_drawer.sv
// Scoreboard bench for gpu_line_drawer.
// Each line that is requested pushes its expected on-screen pixels into
// exp_q. The expected pixels come from a plain integer line walk. A monitor
// pops exp_q and compares on every accepted pixel. The monitor also checks
// that stalled pixels hold, that finished_o is a single pulse, and that every
// line drains exp_q.
module tb_gpu_line_drawer;
    import gpu_pkg::*;

    localparam int WB = 10;
    localparam int HB = 9;
    localparam int CB = 8;
    localparam int SW = 640;
    localparam int SH = 480;

    typedef struct packed {
        logic [WB-1:0] x;
        logic [HB-1:0] y;
        logic [CB-1:0] r;
        logic [CB-1:0] g;
        logic [CB-1:0] b;
    } pix_t;

    logic          clk    = 1'b0;
    logic          n_rst  = 1'b1;
    logic          draw_i = 1'b0;
    logic [WB-1:0] x1_i = '0, x2_i = '0;
    logic [HB-1:0] y1_i = '0, y2_i = '0;
    logic [CB-1:0] r_i = '0, g_i = '0, b_i = '0;
    logic          ready = 1'b1;
    logic          busy_o, finished_o;

    gpu_line_drawer_if #(.WIDTH_BITS(WB), .HEIGHT_BITS(HB), .CHANNEL_BITS(CB)) pix ();
    assign pix.pixel_ready_i = ready;

    gpu_line_drawer #(
        .WIDTH_BITS(WB), .HEIGHT_BITS(HB), .CHANNEL_BITS(CB), .SCREEN_W(SW), .SCREEN_H(SH)
    ) dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .draw_i     (draw_i),
        .x1_i       (x1_i),
        .y1_i       (y1_i),
        .x2_i       (x2_i),
        .y2_i       (y2_i),
        .r_i        (r_i),
        .g_i        (g_i),
        .b_i        (b_i),
        .pix        (pix),
        .busy_o     (busy_o),
        .finished_o (finished_o)
    );

    always #5 clk = ~clk;

    pix_t exp_q[$];
    int   n_checks = 0, n_pass = 0;
    int   cyc = 0, fin_cnt = 0, fin_cyc = 0, last_hs_cyc = 0, hs_cnt = 0;
    bit   fin_armed = 0;
    int   ready_mode = 0;   // 0: always ready, 1: random, 2: driven by a test

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Reference: integer Bresenham over the full line, keeping visible points.
    function automatic int model_line(input int x1, input int y1, input int x2, input int y2,
                                      input logic [CB-1:0] r, input logic [CB-1:0] g,
                                      input logic [CB-1:0] b);
        int dx, dy, sx, sy, err, e2, x, y, n;
        pix_t p;
        dx  = (x2 > x1) ? x2 - x1 : x1 - x2;
        dy  = -((y2 > y1) ? y2 - y1 : y1 - y2);
        sx  = (x1 < x2) ? 1 : -1;
        sy  = (y1 < y2) ? 1 : -1;
        err = dx + dy;
        x   = x1;
        y   = y1;
        n   = 0;
        for (int k = 0; k < 4096; k++) begin
            if (x < SW && y < SH) begin
                p.x = x[WB-1:0]; p.y = y[HB-1:0]; p.r = r; p.g = g; p.b = b;
                exp_q.push_back(p);
                n++;
            end
            if (x == x2 && y == y2) break;
            e2 = 2 * err;
            if (e2 >= dy) begin err += dy; x += sx; end
            if (e2 <= dx) begin err += dx; y += sy; end
        end
        return n;
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial forever begin
        @(posedge clk);
        #1;
        if (ready_mode == 0)      ready = 1'b1;
        else if (ready_mode == 1) ready = ($urandom_range(0, 99) < 65);
    end

    // Monitor
    initial begin
        bit   prev_stall, prev_fin;
        pix_t prev_pix, cur_pix;
        prev_stall = 0;
        prev_fin   = 0;
        prev_pix   = '0;
        forever begin
            @(negedge clk);
            cur_pix = {pix.pixel_x_o, pix.pixel_y_o, pix.pixel_r_o, pix.pixel_g_o, pix.pixel_b_o};
            if (n_rst) begin
                if (prev_stall) begin
                    chk("stall_valid_hold", pix.pixel_valid_o, 1);
                    chk("stall_data_hold", cur_pix, prev_pix);
                end
                if (pix.pixel_valid_o && ready) begin
                    chk("pixel_expected", exp_q.size() > 0, 1);
                    if (exp_q.size() > 0) chk("pixel_data", cur_pix, exp_q.pop_front());
                    hs_cnt++;
                    last_hs_cyc = cyc;
                end
                if (prev_fin) chk("finished_width", finished_o, 0);
                if (finished_o && !prev_fin) begin
                    chk("finished_armed", fin_armed, 1);
                    chk("finished_leftover", exp_q.size(), 0);
                    fin_armed = 0;
                    fin_cnt++;
                    fin_cyc = cyc;
                end
            end
            prev_stall = n_rst && pix.pixel_valid_o && !ready;
            prev_fin   = n_rst && finished_o;
            prev_pix   = cur_pix;
        end
    end

    task automatic run_line(input int x1, input int y1, input int x2, input int y2,
                            input logic [CB-1:0] r, input logic [CB-1:0] g, input logic [CB-1:0] b,
                            input int hold, input bit lat_chk, input bit bp);
        int start_fin, hs0, n_exp;
        @(negedge clk);
        n_exp     = model_line(x1, y1, x2, y2, r, g, b);
        fin_armed = 1;
        start_fin = fin_cnt;
        hs0       = hs_cnt;
        if (bp) ready_mode = 2;
        x1_i = WB'(x1); y1_i = HB'(y1); x2_i = WB'(x2); y2_i = HB'(y2);
        r_i = r; g_i = g; b_i = b;
        draw_i = 1'b1;
        if (lat_chk) begin
            @(negedge clk);
            chk("latency_cycle1_valid", pix.pixel_valid_o, 0);
            chk("busy_in_setup", busy_o, 1);
            @(negedge clk);
            chk("latency_cycle2_valid", pix.pixel_valid_o, 1);
        end
        if (bp) begin
            // The first pixel is taken at the next edge. Ready then drops for
            // three edges while the second pixel is presented.
            @(posedge clk); #1 ready = 1'b0;
            repeat (3) @(posedge clk);
            #1 ready = 1'b1;
        end
        for (int i = 0; i < 4000 && fin_cnt == start_fin; i++) @(negedge clk);
        chk("finished_seen", fin_cnt - start_fin, 1);
        chk("handshake_count", hs_cnt - hs0, n_exp);
        if (lat_chk && !bp) chk("finished_after_last_pixel", fin_cyc - last_hs_cyc, 1);
        if (bp) ready_mode = 0;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("busy_while_held", busy_o, 1);
            chk("no_retrigger_valid", pix.pixel_valid_o, 0);
        end
        chk("no_refinish", fin_cnt - start_fin, 1);
        draw_i = 1'b0;
        repeat (2) @(negedge clk);
        chk("busy_low_after_release", busy_o, 0);
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_valid"}, pix.pixel_valid_o, 0);
        chk({tag, "_xy"}, {pix.pixel_x_o, pix.pixel_y_o}, 0);
        chk({tag, "_rgb"}, {pix.pixel_r_o, pix.pixel_g_o, pix.pixel_b_o}, 0);
        chk({tag, "_busy"}, busy_o, 0);
        chk({tag, "_finished"}, finished_o, 0);
    endtask

    initial begin
        int x1, y1, x2, y2, hs0, fin0, n;
        #1 n_rst = 1'b0;
        #3 check_outputs_zero("reset");
        @(negedge clk);
        @(negedge clk);
        n_rst = 1'b1;

        run_line(0, 0, 3, 0, 8'hFF, 8'h00, 8'h00, 1, 1, 0);
        run_line(0, 0, 1, 3, 8'h12, 8'h34, 8'h56, 0, 0, 0);
        run_line(5, 5, 2, 2, 8'hA0, 8'hB0, 8'hC0, 2, 0, 0);
        run_line(7, 9, 7, 9, 8'h01, 8'h02, 8'h03, 1, 0, 0);
        run_line(0, 0, 3, 0, 8'hFF, 8'h00, 8'h00, 1, 1, 1);
        run_line(638, 0, 641, 0, 8'h0F, 8'hF0, 8'h55, 1, 0, 0);
        run_line(0, 479, 0, 481, 8'h77, 8'h88, 8'h99, 1, 0, 0);
        run_line(10, 10, 14, 12, 8'h11, 8'h22, 8'h33, 10, 0, 0);

        // Reset while the second pixel of a four-pixel line is presented.
        @(negedge clk);
        n    = model_line(0, 0, 3, 0, 8'hAA, 8'hBB, 8'hCC);
        hs0  = hs_cnt;
        fin0 = fin_cnt;
        fin_armed = 1;
        x1_i = '0; y1_i = '0; x2_i = 10'd3; y2_i = '0;
        r_i = 8'hAA; g_i = 8'hBB; b_i = 8'hCC;
        draw_i = 1'b1;
        repeat (3) @(posedge clk);
        #2 n_rst = 1'b0;
        #1 check_outputs_zero("midline_reset");
        chk("pixels_before_reset", hs_cnt - hs0, 1);
        exp_q.delete();
        fin_armed = 0;
        draw_i = 1'b0;
        repeat (2) @(negedge clk);
        n_rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("no_finish_after_reset", fin_cnt - fin0, 0);
        run_line(2, 3, 6, 4, 8'h5A, 8'hA5, 8'h3C, 1, 1, 0);

        ready_mode = 1;
        for (int t = 0; t < 30; t++) begin
            if ($urandom_range(0, 2) == 0) begin
                x1 = int'($urandom_range(615, 665));
                y1 = int'($urandom_range(455, 505));
            end else begin
                x1 = int'($urandom_range(0, 1023));
                y1 = int'($urandom_range(0, 511));
            end
            x2 = x1 + int'($urandom_range(0, 40)) - 20;
            y2 = y1 + int'($urandom_range(0, 40)) - 20;
            if (x2 < 0) x2 = 0;
            if (x2 > 1023) x2 = 1023;
            if (y2 < 0) y2 = 0;
            if (y2 > 511) y2 = 511;
            run_line(x1, y1, x2, y2, 8'($urandom), 8'($urandom), 8'($urandom),
                     int'($urandom_range(0, 3)), 0, 0);
        end
        ready_mode = 0;
        repeat (2) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/gpu_line_drawer.md
Name: gpu_line_drawer

Overview:
- Downstream of the GPU command decoder; consumes its latched draw parameters (x1/y1, x2/y2, r/g/b) and its level-held draw_line strobe.
- Rasterises one endpoint-inclusive line with integer Bresenham and emits one pixel write per cycle over a valid/ready handshake toward the frame-buffer write port.
- Pulses finished_o once when the line is complete; the decoder uses this pulse to return to RESTART.

Parameters:
WIDTH_BITS, 10, x coordinate width (matches `WIDTH_BITS)
HEIGHT_BITS, 9, y coordinate width (matches `HEIGHT_BITS)
CHANNEL_BITS, 8, colour channel width (matches `CHANNEL_BITS)
SCREEN_W, 640, visible columns; pixels with x >= SCREEN_W are clipped
SCREEN_H, 480, visible rows; pixels with y >= SCREEN_H are clipped

Ports:
clk  in  1  system clock, rising edge
n_rst  in  1  asynchronous active-low reset
draw_i  in  1  level request from decoder draw_line_o
x1_i  in  WIDTH_BITS  start x
y1_i  in  HEIGHT_BITS  start y
x2_i  in  WIDTH_BITS  end x
y2_i  in  HEIGHT_BITS  end y
r_i / g_i / b_i  in  CHANNEL_BITS each  line colour
pixel_ready_i  in  1  frame-buffer port accepts the pixel this cycle
pixel_valid_o  out  1  pixel_x/y/r/g/b are valid
pixel_x_o  out  WIDTH_BITS  pixel x
pixel_y_o  out  HEIGHT_BITS  pixel y
pixel_r_o / pixel_g_o / pixel_b_o  out  CHANNEL_BITS each  pixel colour
busy_o  out  1  high in any state except IDLE
finished_o  out  1  one-cycle completion pulse

Behaviour:
- Reset (async, n_rst=0): state IDLE. All outputs and internal registers are 0.
- States: IDLE -> SETUP -> DRAW -> DONE -> WAIT_LOW -> IDLE.
- IDLE: when draw_i=1, latch x1/y1/x2/y2/r/g/b, then go to SETUP. Inputs are ignored after the latch.
- SETUP (1 cycle):
  - dx=|x2-x1|, dy=-|y2-y1|.
  - sx=+1 if x1<x2 else -1; sy=+1 if y1<y2 else -1.
  - err=dx+dy; cur=(x1,y1).
- DRAW, per step:
  - Evaluate cur. If cur is on-screen (x<SCREEN_W and y<SCREEN_H), pixel_valid_o=1 and outputs are registered.
  - The step advances only on valid&&ready. While ready=0, valid and all data hold stable.
  - Off-screen points assert no valid and advance one step per cycle.
  - Advance: if cur==(x2,y2) go to DONE. Otherwise e2=2*err; if e2>=dy then err+=dy, x+=sx; if e2<=dx then err+=dx, y+=sy. Both updates may occur in the same step.
- Latency: draw_i sampled high in IDLE at cycle 0 gives the first pixel_valid_o at cycle 2. Sustained ready gives 1 pixel per cycle.
- Pixel count: max(dx,|dy|)+1 points, each visited exactly once; clipped points are skipped.
- DONE: finished_o=1 for exactly one cycle, pixel_valid_o=0, then go to WAIT_LOW.
- WAIT_LOW: remain until draw_i=0, then go to IDLE. A held draw_i therefore cannot retrigger.
- draw_i falling during SETUP/DRAW is ignored; the line completes.
- err is a signed register of max(WIDTH_BITS,HEIGHT_BITS)+3 bits. e2 is computed at the same width, with no overflow over the full coordinate range.
- Coordinate arithmetic wraps mod 2^WIDTH_BITS / 2^HEIGHT_BITS. Wrap is unreachable because the endpoint terminates the walk first.
- Degenerate line (x1==x2, y1==y2): exactly one point, then DONE.
- Reset mid-DRAW: immediate return to IDLE with outputs 0. No finished pulse is produced.

Decomposition:
- Shared package gpu_pkg:
  - line_state_t enum {IDLE, SETUP, DRAW, DONE, WAIT_LOW}
  - localparam ERR_BITS
- Width defaults come from gpu_definitions.vh.
- One natural combinational sub-module: gpu_bresenham_step (inputs cur x/y, err, dx, dy, sx, sy; outputs next x/y/err and at_end).

Test Plan:
- (0,0)->(3,0), rgb=(FF,00,00), ready=1 -> pixels (0,0),(1,0),(2,0),(3,0) on consecutive cycles starting 2 cycles after draw_i; finished_o 1 cycle after last handshake; busy_o low once draw_i drops.
- (0,0)->(1,3) -> pixels exactly (0,0),(0,1),(1,2),(1,3); (5,5)->(2,2) -> (5,5),(4,4),(3,3),(2,2).
- (7,9)->(7,9) -> single pixel (7,9), then finished_o.
- Backpressure on (0,0)->(3,0): ready=0 for 3 cycles at the 2nd pixel -> (1,0) held stable with valid=1, no skip or duplicate, 4 handshakes total.
- Clip: (638,0)->(641,0) -> only (638,0),(639,0) emitted, finished_o once; (0,479)->(0,481) -> only (0,479).
- draw_i held high 10 cycles after finished_o -> no second line. n_rst pulsed during pixel 2 of a 4-pixel line -> all outputs 0, no finished_o, next draw_i starts cleanly.
